if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
// Instruction-fetch stage plus IF/ID pipeline register; it drives pc4/inst into the decode stage.
// Fetches from an instruction memory with a single outstanding req/ack transaction and variable latency.
// Consumes ID's stall, pcsource, bpc and jpc.
// Implements one branch delay slot: the instruction after a branch/jump always enters ID.
// Inserts NOP bubbles into ID while imem is slow.
// PARAMETERS
// RESET_PC   32'h0000_0000  first fetch address after reset
// NOP_INST   32'h0000_0000  bubble word driven on inst when no valid instruction
// PORTS
// clk         in   1   clock, all state on posedge
// clrn        in   1   reset; synchronous, active-high (asserted = 1 resets on posedge clk)
// stall       in   1   ID load-use stall: hold PC and IF/ID
// pcsource    in   2   ID next-PC select: 00 pc+4, 01 bpc, 10 jpc, 11 reserved (= pc+4)
// bpc         in   32  branch target from ID
// jpc         in   32  jump target from ID
// imem_req    out  1   fetch request; held high with stable addr until imem_ack
// imem_addr   out  32  fetch address (word aligned, [1:0]=00)
// imem_ack    in   1   rdata valid this cycle; ends transaction
// imem_rdata  in   32  instruction word
// pc4         out  32  IF/ID: address of inst + 4
// inst        out  32  IF/ID: instruction, NOP_INST when bubble
// id_valid    out  1   IF/ID: inst is real (0 = bubble)
// BEHAVIOUR
// - Reset: pc=RESET_PC, state=IDLE, imem_req=0, pc4=0, inst=NOP_INST, id_valid=0, hold_v=0, redir_v=0.
// - FSM states: IDLE, FETCH, HOLD.
//   - IDLE: lasts one cycle after reset -> FETCH.
//   - FETCH: imem_req=1, imem_addr=pc.
//     - imem_ack & ~stall: IF/ID <= {pc+4, rdata, 1}; pc <= next_pc; stay in FETCH.
//     - imem_ack & stall: hold_inst <= rdata, hold_v <= 1 -> HOLD.
//     - no ack: IF/ID <= bubble unless stall; if stall, IF/ID holds.
//   - HOLD: imem_req=0. When ~stall: IF/ID <= {pc+4, hold_inst, 1}; pc <= next_pc; hold_v <= 0 -> FETCH.
// - Fetch latency: a request issued in cycle t with ack in cycle t+k reaches ID at edge t+k (k>=0).
// - next_pc when ID holds a valid redirect (id_valid & pcsource in {01,10}):
//   - bpc or jpc is used at the edge the delay slot loads into ID.
// - Otherwise next_pc: redir_v ? redir_pc : pc+4.
// - Pending redirect: if the ID branch leaves ID (bubble load, ~stall) before its delay slot returns:
//   - redir_pc <= target, redir_v <= 1.
//   - Consumed, and redir_v cleared, at the edge the delay slot loads.
// - stall=1: pc, IF/ID, redir_* frozen. An outstanding request is never dropped; its ack is buffered.
// - stall and ack in the same cycle: the buffer captures the word; IF/ID is unchanged.
// - pcsource ignored when id_valid=0.
// - PC arithmetic is modulo 2^32; pc+4 wraps 32'hFFFF_FFFC -> 0.
// - Reset mid-transaction: the state machine is forced to IDLE and imem_req drops next cycle.
//   - A late imem_ack while in IDLE is ignored.
// STRUCTURE
// - Shared package cpu_pkg:
//   - PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JMP=2'b10.
//   - fetch-FSM state encoding.
//   - NOP_INST default.
// - One sub-module: if_next_pc. It is combinational and computes next_pc and the redirect-capture decision.
// - The IF/ID register, hold buffer and FSM stay in the top.
// TESTING
// - Zero-wait imem with ack every cycle after reset, RESET_PC=0:
//   - imem_addr sequence 0,4,8,C.
//   - ID sees pc4=4,8,C with id_valid=1 and no bubbles.
// - Ack delayed 3 cycles on addr 8:
//   - 3 cycles of inst=NOP_INST, id_valid=0.
//   - Then pc4=C, inst=word@8.
// - Branch at 0x10 with pcsource=01, bpc=0x100:
//   - ID sequence 0x10, delay slot 0x14, then 0x100.
//   - 0x18 is never requested.
// - Same as the branch test but the delay-slot ack is delayed 2 cycles:
//   - The branch leaves ID to a bubble and redir_v=1.
//   - After the slot returns, imem_addr=0x100.
// - stall=1 for 2 cycles with an ack in the first stall cycle:
//   - IF/ID is unchanged and imem_req=0 during HOLD.
//   - On release the buffered word loads and no word is lost or duplicated.
// - clrn pulsed while imem_req=1 with ack arriving the next cycle:
//   - The ack is ignored, id_valid=0, and the first new request is at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg - shared next-PC select codes, fetch FSM states, NOP word | rev 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [1:0]  PCSRC_SEQ    = 2'b00;
  localparam logic [1:0]  PCSRC_BR     = 2'b01;
  localparam logic [1:0]  PCSRC_JMP    = 2'b10;

  localparam logic [31:0] CPU_NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_next_pc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_next_pc - next fetch address and redirect-capture decision | rev 1.0
// ---------------------------------------------------------------------------
module if_next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_id_valid,
  input  logic [1:0]  i_pcsource,
  input  logic [31:0] i_bpc,
  input  logic [31:0] i_jpc,
  input  logic        i_redir_v,
  input  logic [31:0] i_redir_pc,
  input  logic        i_bubble_load,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_redir_tgt,
  output logic        o_capture
);

  logic w_id_redir;

  always_comb begin
    o_pc_plus4  = i_pc + 32'd4;
    o_redir_tgt = (i_pcsource == PCSRC_JMP) ? i_jpc : i_bpc;
    w_id_redir  = i_id_valid && ((i_pcsource == PCSRC_BR) || (i_pcsource == PCSRC_JMP));
    // A branch still in ID wins; otherwise a target parked by a branch that already left ID.
    if (w_id_redir) begin
      o_next_pc = o_redir_tgt;
    end else if (i_redir_v) begin
      o_next_pc = i_redir_pc;
    end else begin
      o_next_pc = o_pc_plus4;
    end
    o_capture = w_id_redir && i_bubble_load;
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_fetch_unit - req/ack instruction fetch with IF/ID register, delay slot | rev 1.0
// ---------------------------------------------------------------------------
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = CPU_NOP_INST
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic        id_valid
);

  fetch_state_t r_state, w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_pc4;
  logic [31:0] r_inst;
  logic        r_id_valid;
  logic [31:0] r_hold_inst;
  logic        r_hold_v;
  logic [31:0] r_redir_pc;
  logic        r_redir_v;

  logic        w_load_inst;
  logic        w_load_bubble;
  logic        w_capture_hold;
  logic [31:0] w_word;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic [31:0] w_redir_tgt;
  logic        w_capture;

  if_next_pc u_next_pc (
    .i_pc          (r_pc),
    .i_id_valid    (r_id_valid),
    .i_pcsource    (pcsource),
    .i_bpc         (bpc),
    .i_jpc         (jpc),
    .i_redir_v     (r_redir_v),
    .i_redir_pc    (r_redir_pc),
    .i_bubble_load (w_load_bubble),
    .o_pc_plus4    (w_pc_plus4),
    .o_next_pc     (w_next_pc),
    .o_redir_tgt   (w_redir_tgt),
    .o_capture     (w_capture)
  );

  always_comb begin
    w_state_nxt    = r_state;
    imem_req       = 1'b0;
    w_load_inst    = 1'b0;
    w_load_bubble  = 1'b0;
    w_capture_hold = 1'b0;
    w_word         = imem_rdata;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          // A word arriving during a stall is parked so the transaction is never lost.
          if (stall) begin
            w_capture_hold = 1'b1;
            w_state_nxt    = ST_HOLD;
          end else begin
            w_load_inst = 1'b1;
          end
        end else if (!stall) begin
          w_load_bubble = 1'b1;
        end
      end
      ST_HOLD: begin
        w_word = r_hold_inst;
        if (!stall && r_hold_v) begin
          w_load_inst = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_pc4       <= 32'h0000_0000;
      r_inst      <= NOP_INST;
      r_id_valid  <= 1'b0;
      r_hold_inst <= 32'h0000_0000;
      r_hold_v    <= 1'b0;
      r_redir_pc  <= 32'h0000_0000;
      r_redir_v   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture_hold) begin
        r_hold_inst <= imem_rdata;
        r_hold_v    <= 1'b1;
      end
      if (w_load_inst) begin
        r_pc4      <= w_pc_plus4;
        r_inst     <= w_word;
        r_id_valid <= 1'b1;
        r_pc       <= w_next_pc;
        r_hold_v   <= 1'b0;
        r_redir_v  <= 1'b0;
      end else if (w_load_bubble) begin
        r_inst     <= NOP_INST;
        r_id_valid <= 1'b0;
        if (w_capture) begin
          r_redir_pc <= w_redir_tgt;
          r_redir_v  <= 1'b1;
        end
      end
    end
  end

  assign imem_addr = r_pc;
  assign pc4       = r_pc4;
  assign inst      = r_inst;
  assign id_valid  = r_id_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_if_fetch_unit - directed vector table plus random traffic vs program-order model | rev 1.0
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        clrn;
  logic        stall;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc4;
  logic [31:0] inst;
  logic        id_valid;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_unit dut (
    .clk        (clk),
    .clrn       (clrn),
    .stall      (stall),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .jpc        (jpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc4        (pc4),
    .inst       (inst),
    .id_valid   (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h3C6E_F372 ^ {a[15:0], a[31:16]};
  endfunction

  // Program semantics of a word: its kind selects pcsource, its target is a small aligned address.
  function automatic logic [1:0] word_kind(input logic [31:0] w);
    case (w[4:2])
      3'd0:    return PCSRC_BR;
      3'd1:    return PCSRC_JMP;
      3'd2:    return 2'b11;
      default: return PCSRC_SEQ;
    endcase
  endfunction

  function automatic logic [31:0] word_tgt(input logic [31:0] w);
    return {22'd0, w[12:5], 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ack, input logic st, input logic [1:0] ps,
                       input logic [31:0] b, input logic [31:0] j);
    imem_ack   = ack;
    imem_rdata = mem_word(imem_addr);
    stall      = st;
    pcsource   = ps;
    bpc        = b;
    jpc        = j;
  endtask

  typedef struct {
    logic        ack;
    logic        st;
    logic [1:0]  ps;
    logic [31:0] b;
    logic [31:0] j;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t tv[17];

  // Random-phase state: architectural program-order model.
  logic [31:0] a_pc, a_nxt, a_prev_tgt, w_tmp;
  logic        a_prev_br;
  logic        prev_stall;
  logic [31:0] s_pc4, s_inst;
  logic        s_valid;
  logic        pend_v;
  logic [31:0] pend_addr;
  int          wait_left;
  int          retired;

  initial begin
    tv[0]  = '{1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    tv[1]  = '{1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 32'h4,   1'b1, 32'h4};
    tv[2]  = '{1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 32'h8,   1'b1, 32'h8};
    tv[3]  = '{1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 32'h8,   1'b0, 32'h0};
    tv[4]  = '{1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 32'h8,   1'b0, 32'h0};
    tv[5]  = '{1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 32'h8,   1'b0, 32'h0};
    tv[6]  = '{1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 32'hC,   1'b1, 32'hC};
    tv[7]  = '{1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 32'h10,  1'b1, 32'h10};
    tv[8]  = '{1'b1, 1'b0, 2'b01, 32'h100, 32'h0,   1'b1, 32'h14,  1'b1, 32'h14};
    tv[9]  = '{1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 32'h100, 1'b1, 32'h18};
    tv[10] = '{1'b0, 1'b0, 2'b01, 32'h200, 32'h0,   1'b1, 32'h104, 1'b1, 32'h104};
    tv[11] = '{1'b0, 1'b0, 2'b01, 32'h300, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
    tv[12] = '{1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
    tv[13] = '{1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 32'h200, 1'b1, 32'h108};
    tv[14] = '{1'b1, 1'b0, 2'b10, 32'h990, 32'h40,  1'b1, 32'h204, 1'b1, 32'h204};
    tv[15] = '{1'b1, 1'b0, 2'b11, 32'h300, 32'h500, 1'b1, 32'h40,  1'b1, 32'h208};
    tv[16] = '{1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   1'b1, 32'h44,  1'b1, 32'h44};

    clrn = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req",   {31'd0, imem_req}, 32'd0);
    chk("reset_valid", {31'd0, id_valid}, 32'd0);
    chk("reset_pc4",   pc4, 32'h0);
    chk("reset_inst",  inst, CPU_NOP_INST);
    clrn = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk($sformatf("tv%0d_req", i),   {31'd0, imem_req}, {31'd0, tv[i].e_req});
      chk($sformatf("tv%0d_addr", i),  imem_addr, tv[i].e_addr);
      chk($sformatf("tv%0d_valid", i), {31'd0, id_valid}, {31'd0, tv[i].e_valid});
      if (tv[i].e_valid) begin
        chk($sformatf("tv%0d_pc4", i),  pc4, tv[i].e_pc4);
        chk($sformatf("tv%0d_inst", i), inst, mem_word(tv[i].e_pc4 - 32'd4));
      end else begin
        chk($sformatf("tv%0d_nop", i), inst, CPU_NOP_INST);
      end
      drive(tv[i].ack, tv[i].st, tv[i].ps, tv[i].b, tv[i].j);
    end

    // Stall for two cycles with the ack landing in the first one.
    @(negedge clk);
    chk("st_pre_pc4", pc4, 32'h48);
    chk("st_pre_addr", imem_addr, 32'h48);
    drive(1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("st_hold_req", {31'd0, imem_req}, 32'd0);
    chk("st_hold_pc4", pc4, 32'h48);
    chk("st_hold_inst", inst, mem_word(32'h44));
    drive(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("st_hold2_req", {31'd0, imem_req}, 32'd0);
    chk("st_hold2_pc4", pc4, 32'h48);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("st_rel_pc4", pc4, 32'h4C);
    chk("st_rel_inst", inst, mem_word(32'h48));
    chk("st_rel_addr", imem_addr, 32'h4C);
    chk("st_rel_req", {31'd0, imem_req}, 32'd1);

    // Jump near the top of the address space; sequential fetch wraps to 0.
    drive(1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wr_addr0", imem_addr, 32'hFFFF_FFF8);
    chk("wr_pc4_0", pc4, 32'h50);
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("wr_addr1", imem_addr, 32'hFFFF_FFFC);
    chk("wr_pc4_1", pc4, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("wr_addr2", imem_addr, 32'h0);
    chk("wr_pc4_2", pc4, 32'h0);
    chk("wr_inst2", inst, mem_word(32'hFFFF_FFFC));

    // Reset mid-transaction; the late ack must be ignored.
    chk("rs_pre_req", {31'd0, imem_req}, 32'd1);
    clrn = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("rs_req", {31'd0, imem_req}, 32'd0);
    chk("rs_valid", {31'd0, id_valid}, 32'd0);
    chk("rs_inst", inst, CPU_NOP_INST);
    clrn = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("rs_late_valid", {31'd0, id_valid}, 32'd0);
    chk("rs_first_req", {31'd0, imem_req}, 32'd1);
    chk("rs_first_addr", imem_addr, 32'h0);
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("rs_first_pc4", pc4, 32'h4);
    chk("rs_first_inst", inst, mem_word(32'h0));

    // Random traffic against an architectural delay-slot program model.
    clrn = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    clrn       = 1'b0;
    a_pc       = 32'h0;
    a_prev_br  = 1'b0;
    a_prev_tgt = 32'h0;
    prev_stall = 1'b0;
    pend_v     = 1'b0;
    pend_addr  = 32'h0;
    wait_left  = 0;
    retired    = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        chk("rnd_stall_valid", {31'd0, id_valid}, {31'd0, s_valid});
        chk("rnd_stall_pc4", pc4, s_pc4);
        chk("rnd_stall_inst", inst, s_inst);
      end else if (id_valid) begin
        chk("rnd_pc4", pc4, a_pc + 32'd4);
        chk("rnd_inst", inst, mem_word(a_pc));
        a_nxt      = a_prev_br ? a_prev_tgt : a_pc + 32'd4;
        w_tmp      = mem_word(a_pc);
        a_prev_br  = (word_kind(w_tmp) == PCSRC_BR) || (word_kind(w_tmp) == PCSRC_JMP);
        a_prev_tgt = word_tgt(w_tmp);
        a_pc       = a_nxt;
        retired++;
      end else begin
        chk("rnd_bubble", inst, CPU_NOP_INST);
      end
      if (pend_v) begin
        chk("rnd_req_held", {31'd0, imem_req}, 32'd1);
        chk("rnd_addr_stable", imem_addr, pend_addr);
      end
      s_valid = id_valid;
      s_pc4   = pc4;
      s_inst  = inst;

      stall = ($urandom_range(0, 9) == 0);
      if (id_valid) begin
        pcsource = word_kind(inst);
        bpc      = (pcsource == PCSRC_BR)  ? word_tgt(inst) : {$urandom_range(0, 255), 2'b00};
        jpc      = (pcsource == PCSRC_JMP) ? word_tgt(inst) : {$urandom_range(0, 255), 2'b00};
      end else begin
        pcsource = 2'($urandom_range(0, 3));
        bpc      = {$urandom_range(0, 255), 2'b00};
        jpc      = {$urandom_range(0, 255), 2'b00};
      end
      imem_ack = 1'b0;
      pend_v   = 1'b0;
      if (imem_req) begin
        if (wait_left == 0) begin
          imem_ack  = 1'b1;
          wait_left = $urandom_range(0, 3);
        end else begin
          wait_left--;
          pend_v    = 1'b1;
          pend_addr = imem_addr;
        end
      end
      imem_rdata = mem_word(imem_addr);
      prev_stall = stall;
    end
    chk("rnd_progress", {31'd0, retired >= 400}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
